// File: rtl/nv_nvdla_dmaif_pkg.sv
// Shared DMA interface definitions for the SDP read path: payload widths,
// field positions inside the request/response payloads and the burst FSM states.
package nv_nvdla_dmaif_pkg;

  localparam int RD_REQ_PD_W  = 47;
  localparam int RD_RSP_PD_W  = 257;
  localparam int ATOM_BYTES   = 32;

  // Request payload: {size[14:0], addr[31:0]}
  localparam int REQ_ADDR_LSB = 0;
  localparam int REQ_ADDR_MSB = 31;
  localparam int REQ_SIZE_LSB = 32;
  localparam int REQ_SIZE_MSB = 46;

  // Response payload: {mask[0], data[255:0]}
  localparam int RSP_DATA_LSB = 0;
  localparam int RSP_DATA_MSB = 255;
  localparam int RSP_MASK_BIT = 256;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/nv_nvdla_sdp_mcif_rd_rsp_skid.sv
// Two-entry valid/ready FIFO holding returned read data until the consumer
// accepts it. Occupancy is exported so the issuer can reserve space per read.
module nv_nvdla_sdp_mcif_rd_rsp_skid #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] entry [2];
  logic              wr_sel;
  logic              rd_sel;
  logic              pop;

  assign valid = (count != 2'd0);
  assign pop   = valid & ready;
  assign data  = entry[rd_sel];

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_sel <= ~wr_sel;
      if (pop)  rd_sel <= ~rd_sel;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage is not reset; only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) entry[wr_sel] <= push_data;
  end

endmodule

// File: rtl/nv_nvdla_sdp_mcif_rd_responder.sv
// Memory-side responder for SDP read DMA: queues read requests, walks each
// request atom by atom against a synchronous RAM port, and returns one
// 32-byte atom per response beat in request order with full backpressure.
module nv_nvdla_sdp_mcif_rd_responder
  import nv_nvdla_dmaif_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int ADDR_W    = 32,
  parameter int SIZE_W    = 15
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic [RD_REQ_PD_W-1:0] rd_req_pd,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  output logic [RD_RSP_PD_W-1:0] rd_rsp_pd,
  output logic                   rd_rsp_valid,
  input  logic                   rd_rsp_ready,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_rd_addr,
  input  logic [255:0]           mem_rd_data,
  output logic                   idle
);

  localparam int PTR_W = $clog2(REQ_DEPTH);

  // ---------------- request FIFO ----------------
  logic [RD_REQ_PD_W-1:0] req_mem [REQ_DEPTH];
  logic [PTR_W:0]         req_wr_ptr;
  logic [PTR_W:0]         req_rd_ptr;
  logic                   req_empty;
  logic                   req_full;
  logic                   req_push;
  logic                   req_pop;
  logic                   ready_en;
  logic [RD_REQ_PD_W-1:0] head_pd;
  logic [ADDR_W-1:0]      head_addr;
  logic [SIZE_W-1:0]      head_size;

  assign req_empty    = (req_wr_ptr == req_rd_ptr);
  assign req_full     = (req_wr_ptr[PTR_W] != req_rd_ptr[PTR_W]) &&
                        (req_wr_ptr[PTR_W-1:0] == req_rd_ptr[PTR_W-1:0]);
  // ready_en keeps the port closed through the reset cycle and opens it the cycle after.
  assign rd_req_ready = ready_en & ~req_full & ~nvdla_core_rst;
  assign req_push     = rd_req_valid & rd_req_ready;
  assign head_pd      = req_mem[req_rd_ptr[PTR_W-1:0]];
  assign head_addr    = head_pd[REQ_ADDR_MSB:REQ_ADDR_LSB];
  assign head_size    = head_pd[REQ_SIZE_MSB:REQ_SIZE_LSB];

  // Request FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      ready_en   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (req_push) req_wr_ptr <= req_wr_ptr + 1'b1;
      if (req_pop)  req_rd_ptr <= req_rd_ptr + 1'b1;
    end
  end

  // Request payload storage, qualified by the pointers.
  always_ff @(posedge nvdla_core_clk) begin
    if (req_push) req_mem[req_wr_ptr[PTR_W-1:0]] <= rd_req_pd;
  end

  // ---------------- burst walker / read issue (p0) ----------------
  rd_state_e         state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [SIZE_W-1:0] remain, remain_nxt;
  logic              issue;
  logic              credit_ok;
  logic              rd_vld_p1;
  logic [1:0]        skid_count;
  logic [1:0]        skid_used;
  logic              skid_pop;
  logic [255:0]      skid_data;

  // A read needs a free skid slot, counting the read already in flight;
  // a beat leaving this cycle frees its slot immediately.
  assign skid_pop  = rd_rsp_valid & rd_rsp_ready;
  assign skid_used = skid_count + {1'b0, rd_vld_p1};
  assign credit_ok = (skid_used < 2'd2) | skid_pop;

  // Next-state: IDLE loads the head request; BURST issues one atom per credit
  // and chains straight into the next request when the current one ends.
  always_comb begin
    state_nxt    = state;
    cur_addr_nxt = cur_addr;
    remain_nxt   = remain;
    req_pop      = 1'b0;
    issue        = 1'b0;
    case (state)
      IDLE: begin
        if (!req_empty) begin
          req_pop      = 1'b1;
          cur_addr_nxt = head_addr;
          remain_nxt   = head_size;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remain == '0) begin
            if (!req_empty) begin
              req_pop      = 1'b1;
              cur_addr_nxt = head_addr;
              remain_nxt   = head_size;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cur_addr_nxt = cur_addr + ADDR_W'(ATOM_BYTES);
            remain_nxt   = remain - SIZE_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Walker state, current atom address and remaining atom count.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      remain   <= '0;
    end else begin
      state    <= state_nxt;
      cur_addr <= cur_addr_nxt;
      remain   <= remain_nxt;
    end
  end

  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? cur_addr : '0;

  // ---------------- RAM return (p1): data valid one cycle after issue ----------------
  // Tracks the single read in flight so its data is captured on return.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) rd_vld_p1 <= 1'b0;
    else                rd_vld_p1 <= issue;
  end

  nv_nvdla_sdp_mcif_rd_rsp_skid #(
    .DATA_W (256)
  ) u_skid (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .push      (rd_vld_p1),
    .push_data (mem_rd_data),
    .ready     (rd_rsp_ready),
    .valid     (rd_rsp_valid),
    .data      (skid_data),
    .count     (skid_count)
  );

  assign rd_rsp_pd[RSP_MASK_BIT]              = 1'b1;
  assign rd_rsp_pd[RSP_DATA_MSB:RSP_DATA_LSB] = skid_data;

  assign idle = req_empty & (state == IDLE) & ~rd_vld_p1 & (skid_count == 2'd0);

endmodule

// File: tb/tb_nv_nvdla_sdp_mcif_rd_responder.sv
// Bench for the SDP MCIF read responder: RAM stub, table-driven request vectors,
// hand-written latency/backpressure/reset sequences and a randomized phase, all
// checked against an address-queue reference model.
module tb_nv_nvdla_sdp_mcif_rd_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [46:0]  rd_req_pd = '0;
  logic         rd_req_valid = 1'b0;
  logic         rd_req_ready;
  logic [256:0] rd_rsp_pd;
  logic         rd_rsp_valid;
  logic         rd_rsp_ready = 1'b1;
  logic         mem_rd_en;
  logic [31:0]  mem_rd_addr;
  logic [255:0] mem_rd_data;
  logic         idle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never
  int ready_phase = 0;

  // Reference model state
  logic [31:0]  exp_q[$];
  int           pop_cyc_q[$];
  int           issued_total = 0;
  int           popped_total = 0;
  int           outstanding = 0;
  logic [31:0]  last_issue_addr = '0;
  logic         prev_stall = 1'b0;
  logic [256:0] prev_pd = '0;

  always #5 clk = ~clk;

  nv_nvdla_sdp_mcif_rd_responder dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .rd_req_pd      (rd_req_pd),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_rsp_pd      (rd_rsp_pd),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_ready   (rd_rsp_ready),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .idle           (idle)
  );

  function automatic logic [255:0] ram_word(input logic [31:0] a);
    logic [255:0] w;
    for (int i = 0; i < 8; i++)
      w[i*32 +: 32] = (a * 32'h9E3779B1) ^ (32'h01010101 * 32'(i)) ^ {a[15:0], a[31:16]};
    return w;
  endfunction

  // Synchronous RAM stub; garbage on idle cycles exposes mistimed captures.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram_word(mem_rd_addr);
    else           mem_rd_data <= {8{$urandom}};
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: rd_rsp_ready = 1'b1;
      1: begin
        rd_rsp_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
        ready_phase++;
      end
      2: rd_rsp_ready = 1'($urandom_range(0, 1));
      default: rd_rsp_ready = 1'b0;
    endcase
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [256:0] got, input logic [256:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Reference model: each accepted request expands to its atom addresses; each
  // accepted beat must carry the RAM word of the oldest outstanding address.
  task automatic monitor();
    logic [31:0] a;
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
      return;
    end
    if (rd_req_valid && rd_req_ready)
      for (int k = 0; k <= int'(rd_req_pd[46:32]); k++)
        exp_q.push_back(rd_req_pd[31:0] + 32'(k * 32));
    if (mem_rd_en) begin
      issued_total++;
      last_issue_addr = mem_rd_addr;
      outstanding++;
    end
    if (prev_stall) begin
      chk("rsp_hold_valid", 257'(rd_rsp_valid), 257'(1));
      chk("rsp_hold_pd", rd_rsp_pd, prev_pd);
    end
    if (rd_rsp_valid && rd_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got=%0h want=none", rd_rsp_pd);
      end else begin
        a = exp_q.pop_front();
        chk("beat_pd", rd_rsp_pd, {1'b1, ram_word(a)});
      end
      popped_total++;
      pop_cyc_q.push_back(cyc);
      outstanding--;
    end
    if (mem_rd_en) chk("read_credit", 257'(outstanding <= 2), 257'(1));
    prev_stall = rd_rsp_valid && !rd_rsp_ready;
    prev_pd    = rd_rsp_pd;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [14:0] s, input int budget,
                          output bit ok);
    bit acc;
    rd_req_pd    = {s, a};
    rd_req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      acc = rd_req_ready;
      step();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    rd_req_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (!(idle && exp_q.size() == 0) && c < budget) begin
      step();
      c++;
    end
    chk(name, 257'(c < budget), 257'(1));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [14:0] size;
    int          mode;
    int          beats;
    logic [31:0] last_addr;
    int          span;     // cycles from first to last beat, -1 = unchecked
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit ok;
    bit bp;
    int bi, bq, total;
    logic [31:0] ra;
    logic [14:0] rs;

    vecs[0] = '{32'h0000_1000, 15'd0, 0, 1,  32'h0000_1000, 0};
    vecs[1] = '{32'h0000_2000, 15'd3, 0, 4,  32'h0000_2060, 3};
    vecs[2] = '{32'h0000_2000, 15'd3, 1, 4,  32'h0000_2060, -1};
    vecs[3] = '{32'hFFFF_FFC0, 15'd2, 0, 3,  32'h0000_0000, 2};
    vecs[4] = '{32'h0000_7F00, 15'd9, 2, 10, 32'h0000_8020, -1};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_req_ready", 257'(rd_req_ready), 257'(0));
    chk("rst_rsp_valid", 257'(rd_rsp_valid), 257'(0));
    chk("rst_mem_rd_en", 257'(mem_rd_en), 257'(0));
    chk("rst_mem_rd_addr", 257'(mem_rd_addr), 257'(0));
    chk("rst_idle", 257'(idle), 257'(1));
    rst = 1'b0;
    step();
    chk("post_rst_req_ready", 257'(rd_req_ready), 257'(1));

    // First-beat latency from an empty pipe
    rd_req_pd    = {15'd0, 32'h0000_1000};
    rd_req_valid = 1'b1;
    step();
    rd_req_valid = 1'b0;
    step();
    step();
    chk("lat_not_early", 257'(rd_rsp_valid), 257'(0));
    step();
    chk("lat_valid", 257'(rd_rsp_valid), 257'(1));
    chk("lat_pd", rd_rsp_pd, {1'b1, ram_word(32'h0000_1000)});
    step();
    chk("lat_idle_after", 257'(idle), 257'(1));

    // Table-driven request vectors
    for (int v = 0; v < 5; v++) begin
      ready_mode = vecs[v].mode;
      step();
      bi = issued_total;
      bq = popped_total;
      push_req(vecs[v].addr, vecs[v].size, 20, ok);
      chk($sformatf("vec%0d_accept", v), 257'(ok), 257'(1));
      drain($sformatf("vec%0d_drain", v), 400);
      chk($sformatf("vec%0d_issued", v), 257'(issued_total - bi), 257'(vecs[v].beats));
      chk($sformatf("vec%0d_last_addr", v), 257'(last_issue_addr), 257'(vecs[v].last_addr));
      chk($sformatf("vec%0d_beats", v), 257'(popped_total - bq), 257'(vecs[v].beats));
      if (vecs[v].span >= 0 && popped_total - bq == vecs[v].beats)
        chk($sformatf("vec%0d_span", v),
            257'(pop_cyc_q[bq + vecs[v].beats - 1] - pop_cyc_q[bq]), 257'(vecs[v].span));
    end

    // Backpressure: eight single-atom requests against a stalled consumer
    ready_mode = 3;
    step();
    bq = popped_total;
    bp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_req(32'h0000_3000 + 32'(i * 64), 15'd0, 20, ok);
      if (!ok) begin
        bp = 1'b1;
        ready_mode = 0;
        push_req(32'h0000_3000 + 32'(i * 64), 15'd0, 50, ok);
        chk("bp_retry_accept", 257'(ok), 257'(1));
      end
    end
    chk("bp_ready_dropped", 257'(bp), 257'(1));
    ready_mode = 0;
    drain("bp_drain", 500);
    chk("bp_beats", 257'(popped_total - bq), 257'(8));

    // Reset in the middle of an 8-atom burst
    ready_mode = 0;
    step();
    bq = popped_total;
    push_req(32'h0000_5000, 15'd7, 20, ok);
    chk("rst_burst_accept", 257'(ok), 257'(1));
    bi = 0;
    while (popped_total - bq < 2 && bi < 100) begin
      step();
      bi++;
    end
    chk("rst_two_beats_seen", 257'(popped_total - bq >= 2), 257'(1));
    rst = 1'b1;
    step();
    chk("mid_rst_rsp_valid", 257'(rd_rsp_valid), 257'(0));
    chk("mid_rst_idle", 257'(idle), 257'(1));
    chk("mid_rst_mem_rd_en", 257'(mem_rd_en), 257'(0));
    chk("mid_rst_req_ready", 257'(rd_req_ready), 257'(0));
    rst = 1'b0;
    bi = issued_total;
    bq = popped_total;
    repeat (10) step();
    chk("post_rst_no_issue", 257'(issued_total - bi), 257'(0));
    chk("post_rst_no_beat", 257'(popped_total - bq), 257'(0));
    chk("post_rst_idle", 257'(idle), 257'(1));
    push_req(32'h0000_6000, 15'd1, 20, ok);
    chk("post_rst_accept", 257'(ok), 257'(1));
    drain("post_rst_drain", 200);
    chk("post_rst_beats", 257'(popped_total - bq), 257'(2));

    // Randomized requests with random consumer backpressure
    ready_mode = 2;
    bq = popped_total;
    total = 0;
    for (int i = 0; i < 20; i++) begin
      ra = $urandom & 32'hFFFF_FFE0;
      rs = 15'($urandom_range(0, 6));
      push_req(ra, rs, 200, ok);
      chk("rand_accept", 257'(ok), 257'(1));
      if (ok) total += int'(rs) + 1;
    end
    drain("rand_drain", 3000);
    chk("rand_beats", 257'(popped_total - bq), 257'(total));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
